// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key index constants follow the downstream decoder's one-hot map.
package keypad_pkg;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;
   localparam int unsigned KEYS = ROWS * COLS;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      EVAL
   } state_t;

   localparam logic [3:0] KEY_ENTER = 4'd0;
   localparam logic [3:0] KEY_0     = 4'd3;
   localparam logic [3:0] KEY_SET   = 4'd4;
   localparam logic [3:0] KEY_3     = 4'd5;
   localparam logic [3:0] KEY_2     = 4'd6;
   localparam logic [3:0] KEY_1     = 4'd7;
   localparam logic [3:0] KEY_CLR   = 4'd8;
   localparam logic [3:0] KEY_6     = 4'd9;
   localparam logic [3:0] KEY_5     = 4'd10;
   localparam logic [3:0] KEY_4     = 4'd11;
   localparam logic [3:0] KEY_BKSP  = 4'd12;
   localparam logic [3:0] KEY_9     = 4'd13;
   localparam logic [3:0] KEY_8     = 4'd14;
   localparam logic [3:0] KEY_7     = 4'd15;

   // Concatenation equals row*4+col for a 4-column matrix.
   function automatic logic [3:0] onehot_index(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the debounced key-code bus toward the decoder.
// master = scanner side, slave = matrix/decoder side.
interface keypad_scanner_if;
   import keypad_pkg::*;

   logic [COLS-1:0] col_n;
   logic [ROWS-1:0] row_n;
   logic [KEYS-1:0] onehot;
   logic [3:0]      key_code;
   logic            key_valid;

   modport master (
      input  col_n,
      output row_n,
      output onehot,
      output key_code,
      output key_valid
   );

   modport slave (
      output col_n,
      input  row_n,
      input  onehot,
      input  key_code,
      input  key_valid
   );

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle-high column lines
// never look like a keypress coming out of reset.
module sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: rotates row strobes, samples columns at the end of each
// row period, and commits a one-hot key code after several identical frames.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 50000,
   parameter int unsigned DEBOUNCE_FRAMES = 5
) (
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master bus
);

   localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       CNT_MAX = 4'(DEBOUNCE_FRAMES - 1);

   logic [COLS-1:0]  col_sync;
   logic             tc;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       row_q, row_d;
   logic [KEYS-1:0]  frame_q, frame_d;
   logic [KEYS-1:0]  cand_q, cand_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [KEYS-1:0]  onehot_q, onehot_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;

   logic [4:0]       cand_pop;
   logic [3:0]       cand_idx;

   sync2 #(.WIDTH(COLS)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.col_n),
      .q_o (col_sync)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         row_q    <= '0;
         frame_q  <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         onehot_q <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         row_q    <= row_d;
         frame_q  <= frame_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         onehot_q <= onehot_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      cand_pop = '0;
      cand_idx = '0;
      for (int unsigned i = 0; i < KEYS; i++) begin
         if (cand_q[i]) begin
            cand_pop = cand_pop + 5'd1;
            cand_idx = 4'(i);
         end
      end
   end

   // The row sequencer free-runs in every state, so EVAL never stretches row 0.
   always_comb begin
      tc       = (div_q == DIV_MAX);
      div_d    = tc ? '0 : div_q + 1'b1;
      row_d    = tc ? row_q + 2'd1 : row_q;
      state_d  = state_q;
      frame_d  = frame_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      onehot_d = onehot_q;
      code_d   = code_q;
      valid_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (tc) state_d = SCAN;
         end
         SCAN: begin
            if (tc) begin
               frame_d[{row_q, 2'b00} +: COLS] = ~col_sync;
               if (row_q == 2'd3) state_d = EVAL;
            end
         end
         EVAL: begin
            state_d = SCAN;
            if (frame_q == cand_q) begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
               // Commit only happens on the equal path, so cand_q is the final candidate here.
               if (cnt_d == CNT_MAX && cand_q != onehot_q) begin
                  if (cand_pop == 5'd0) begin
                     onehot_d = '0;
                  end else if (cand_pop == 5'd1) begin
                     onehot_d = cand_q;
                     code_d   = cand_idx;
                     valid_d  = 1'b1;
                  end
               end
            end else begin
               cnt_d  = '0;
               cand_d = frame_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.row_n     = ~(4'b0001 << row_q);
   assign bus.onehot    = onehot_q;
   assign bus.key_code  = code_q;
   assign bus.key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives the columns
// from a pressed-key mask, and checks come from hand-computed tables.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEB      = 3;

   typedef struct {
      logic [15:0] keys;
      logic [15:0] onehot;
      logic [3:0]  code;
      int unsigned pulses;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] keys = '0;
   logic [3:0]  col_model;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned pulses = 0;

   keypad_scanner_if kif ();

   keypad_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_FRAMES (DEB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (kif)
   );

   always #5 clk = ~clk;

   // A held key shorts its column low while its row strobe is low.
   always_comb begin
      col_model = '1;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[r*4+c] && !kif.row_n[r]) col_model[c] = 1'b0;
   end
   assign kif.col_n = col_model;

   always @(negedge clk) if (kif.key_valid) pulses++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int unsigned got,
                              input int unsigned lo, input int unsigned hi);
      n_cmp++;
      if (got < lo || got > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   task automatic align_row1;
      logic [3:0] prev;
      bit         found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         prev = kif.row_n;
         @(negedge clk);
         if (prev == 4'b1110 && kif.row_n == 4'b1101) found = 1'b1;
      end
      check("row1_align", 32'(found), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   vec_t        tbl [12];
   logic [3:0]  exp_row;
   int unsigned p0;
   int unsigned n;

   initial begin
      tbl[0]  = '{16'h0000, 16'h0000, 4'd0,  0};
      tbl[1]  = '{16'h0040, 16'h0040, 4'd6,  1};
      tbl[2]  = '{16'h0000, 16'h0000, 4'd6,  0};
      tbl[3]  = '{16'h2100, 16'h0000, 4'd6,  0};
      tbl[4]  = '{16'h2000, 16'h2000, 4'd13, 1};
      tbl[5]  = '{16'h0080, 16'h0080, 4'd7,  1};
      tbl[6]  = '{16'h8000, 16'h8000, 4'd15, 1};
      tbl[7]  = '{16'h0000, 16'h0000, 4'd15, 0};
      tbl[8]  = '{16'h0001, 16'h0001, 4'd0,  1};
      tbl[9]  = '{16'h0003, 16'h0001, 4'd0,  0};
      tbl[10] = '{16'h0002, 16'h0002, 4'd1,  1};
      tbl[11] = '{16'h0000, 16'h0000, 4'd1,  0};

      repeat (3) @(negedge clk);
      check("rst_row_n",     32'(kif.row_n),     32'h0000_000e);
      check("rst_onehot",    32'(kif.onehot),    32'h0);
      check("rst_key_code",  32'(kif.key_code),  32'h0);
      check("rst_key_valid", 32'(kif.key_valid), 32'h0);

      rst = 1'b0;
      p0  = pulses;
      for (int t = 0; t < 32; t++) begin
         exp_row = ~(4'b0001 << ((t / 4) % 4));
         check("idle_row_n", 32'(kif.row_n), 32'(exp_row));
         check("idle_onehot", 32'(kif.onehot), 32'h0);
         @(negedge clk);
      end
      check("idle_pulses", pulses - p0, 32'd0);

      for (int i = 0; i < 12; i++) begin
         keys = tbl[i].keys;
         p0   = pulses;
         repeat (80) @(negedge clk);
         check($sformatf("vec%0d_onehot", i), 32'(kif.onehot), 32'(tbl[i].onehot));
         check($sformatf("vec%0d_code", i),   32'(kif.key_code), 32'(tbl[i].code));
         check($sformatf("vec%0d_pulses", i), pulses - p0, tbl[i].pulses);
      end

      // Press latency with the press placed mid row-1 period.
      align_row1();
      keys = 16'h0040;
      p0   = pulses;
      n    = 0;
      while (kif.onehot !== 16'h0040 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_range("press_latency", n, 51, 67);
      check("press_valid_hi", 32'(kif.key_valid), 32'd1);
      check("press_code", 32'(kif.key_code), 32'd6);
      @(negedge clk);
      check("press_valid_lo", 32'(kif.key_valid), 32'd0);
      repeat (40) @(negedge clk);
      check("press_pulses", pulses - p0, 32'd1);

      align_row1();
      keys = 16'h0000;
      p0   = pulses;
      n    = 0;
      while (kif.onehot !== 16'h0000 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_range("release_latency", n, 51, 67);
      repeat (20) @(negedge clk);
      check("release_code_hold", 32'(kif.key_code), 32'd6);
      check("release_pulses", pulses - p0, 32'd0);

      // Bouncing contact on row0/col3, then held steady.
      p0 = pulses;
      for (int i = 0; i < 6; i++) begin
         keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
         repeat (5) @(negedge clk);
      end
      keys = 16'h0008;
      repeat (150) @(negedge clk);
      check("bounce_onehot", 32'(kif.onehot), 32'h0008);
      check("bounce_code", 32'(kif.key_code), 32'd3);
      check("bounce_pulses", pulses - p0, 32'd1);
      keys = 16'h0000;
      repeat (100) @(negedge clk);
      check("bounce_release", 32'(kif.onehot), 32'h0);

      // Asynchronous reset while a key is committed and still held.
      keys = 16'h0100;
      repeat (100) @(negedge clk);
      check("pre_rst_onehot", 32'(kif.onehot), 32'h0100);
      #2 rst = 1'b1;
      #1;
      check("async_rst_row_n",  32'(kif.row_n),     32'h0000_000e);
      check("async_rst_onehot", 32'(kif.onehot),    32'h0);
      check("async_rst_code",   32'(kif.key_code),  32'h0);
      check("async_rst_valid",  32'(kif.key_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      n   = 0;
      while (kif.onehot !== 16'h0100 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_range("post_rst_latency", n, 3 * 16, 67);
      check("post_rst_valid", 32'(kif.key_valid), 32'd1);
      check("post_rst_code", 32'(kif.key_code), 32'(KEY_CLR));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
